// File: rtl/data_mem_ctrl.sv
// Data memory behind a valid/ready request port with byte-lane writes, RD_LAT-cycle responses,
// out-of-range error flagging and an optional zeroing sweep after reset.
module data_mem_ctrl #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);

    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic                r_ready, r_init_done;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_accept, w_oor, w_init_wr, w_req_wr;
    logic [DATA_W-1:0]   w_s1_rdata;
    logic                r_s1_valid, r_s1_err;
    logic [DATA_W-1:0]   r_s1_rdata;

    // Requests arriving on a reset edge are ignored; zero-extended compare folds to 0 when DEPTH fills the space
    assign w_accept = req_valid && r_ready && reset;
    assign w_oor    = ({1'b0, req_addr} >= DEPTH_L);
    assign w_req_wr = w_accept && req_we && !w_oor;

    // Next-state logic for the clear sweep
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_init_wr   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_wr = 1'b1;
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_L) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State, sweep counter and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= (w_state_nxt == ST_READY);
            r_init_done <= (w_state_nxt == ST_READY);
        end
    end

    // Storage array: not reset so contents survive when the sweep is disabled
    always_ff @(posedge clk) begin
        if (reset && w_init_wr) begin
            r_mem[r_cnt] <= '0;
        end else if (w_req_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is taken from the array before this edge's write lands (only one request per edge)
    always_comb begin
        w_s1_rdata = '0;
        if (w_accept && !req_we && !w_oor) begin
            w_s1_rdata = r_mem[req_addr];
        end else begin
            w_s1_rdata = '0;
        end
    end

    // First response stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_rdata <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_err   <= w_accept && w_oor;
            r_s1_rdata <= w_s1_rdata;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s2_valid, r_s2_err;
            logic [DATA_W-1:0] r_s2_rdata;

            // Extra response stage for two-cycle latency
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_s2_valid <= 1'b0;
                    r_s2_err   <= 1'b0;
                    r_s2_rdata <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_err   <= r_s1_err;
                    r_s2_rdata <= r_s1_rdata;
                end
            end

            assign rsp_valid = r_s2_valid;
            assign rsp_err   = r_s2_err;
            assign rsp_rdata = r_s2_rdata;
        end else begin : g_lat1
            assign rsp_valid = r_s1_valid;
            assign rsp_err   = r_s1_err;
            assign rsp_rdata = r_s1_rdata;
        end
    endgenerate

    assign req_ready = r_ready;
    assign init_done = r_init_done;

endmodule
